// File: rtl/fetch_pkg.sv
// Shared types and constants for the 3BC fetch sequencer.
// Program entry points live here so the ROM map is defined in one place.
package fetch_pkg;

    localparam int ADDR_W     = 10;
    localparam int NUM_PROGS  = 3;
    localparam int PROG_SEL_W = 2;

    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

    typedef logic [ADDR_W-1:0] inst_addr_t;

    localparam inst_addr_t START_ADDR [NUM_PROGS] = '{10'd0, 10'd256, 10'd512};

    // Unmapped program indices fall back to address 0.
    function automatic inst_addr_t startAddr(input logic [PROG_SEL_W-1:0] sel);
        inst_addr_t addr;
        addr = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (int'(sel) == i) begin
                addr = START_ADDR[i];
            end
        end
        return addr;
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// Combinational next-PC selection: branch target or sequential increment,
// flagging when the increment rolls over the top of the ROM.
module pc_next
    import fetch_pkg::*;
(
    input  inst_addr_t pc_i,
    input  logic       branchEn_i,
    input  inst_addr_t target_i,
    output inst_addr_t pcNext_o,
    output logic       wrap_o
);

    // A branch landing anywhere never counts as wrapping.
    always_comb begin
        pcNext_o = pc_i + inst_addr_t'(1);
        wrap_o   = 1'b0;
        if (branchEn_i) begin
            pcNext_o = target_i;
        end else if (pc_i == {ADDR_W{1'b1}}) begin
            wrap_o = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer for the 3BC processor (Start/Done handshake).
// Define FETCH_INST_COUNT_EN to add the saturating instCount_o output.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [PROG_SEL_W-1:0] progSel_i,
    input  logic                  stall_i,
    input  logic                  halt_i,
    input  logic                  branchEn_i,
    input  inst_addr_t            target_i,
    output inst_addr_t            instAddress_o,
    output logic                  instValid_o,
    output logic                  done_o,
    output logic                  wrapped_o
`ifdef FETCH_INST_COUNT_EN
    ,
    output logic [15:0]           instCount_o
`endif
);

    fetch_state_t state_q, state_d;
    inst_addr_t   pc_q, pc_d;
    logic         wrapped_q, wrapped_d;
    inst_addr_t   pcNext;
    logic         pcWrap;

    pc_next u_pcNext (
        .pc_i       (pc_q),
        .branchEn_i (branchEn_i),
        .target_i   (target_i),
        .pcNext_o   (pcNext),
        .wrap_o     (pcWrap)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Stall outranks Halt, which outranks a taken branch; Start only matters outside RUN.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrapped_d = wrapped_q;
        case (state_q)
            RUN: begin
                if (!stall_i) begin
                    if (halt_i) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pcNext;
                        if (pcWrap) begin
                            wrapped_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (start_i) begin
                    state_d   = RUN;
                    pc_d      = startAddr(progSel_i);
                    wrapped_d = 1'b0;
                end
            end
        endcase
    end

    assign instAddress_o = pc_q;
    assign instValid_o   = (state_q == RUN);
    assign done_o        = (state_q == HALT);
    assign wrapped_o     = wrapped_q;

`ifdef FETCH_INST_COUNT_EN
    logic [15:0] instCount_q, instCount_d;

    // Counts every unstalled RUN edge, including the one that takes the halt.
    always_comb begin
        instCount_d = instCount_q;
        if (state_q == RUN) begin
            if (!stall_i && instCount_q != 16'hFFFF) begin
                instCount_d = instCount_q + 16'd1;
            end
        end else if (start_i) begin
            instCount_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instCount_q <= 16'd0;
        end else begin
            instCount_q <= instCount_d;
        end
    end

    assign instCount_o = instCount_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural program-sequencer model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  progSel_i = 2'd0;
    logic        stall_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        branchEn_i = 1'b0;
    logic [9:0]  target_i = 10'd0;
    logic [9:0]  instAddress_o;
    logic        instValid_o;
    logic        done_o;
    logic        wrapped_o;
`ifdef FETCH_INST_COUNT_EN
    logic [15:0] instCount_o;
`endif

    int checks = 0;
    int failures = 0;

    fetch_ctrl dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .progSel_i     (progSel_i),
        .stall_i       (stall_i),
        .halt_i        (halt_i),
        .branchEn_i    (branchEn_i),
        .target_i      (target_i),
        .instAddress_o (instAddress_o),
        .instValid_o   (instValid_o),
        .done_o        (done_o),
        .wrapped_o     (wrapped_o)
`ifdef FETCH_INST_COUNT_EN
        ,
        .instCount_o   (instCount_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Model: the program is either idle, running, or finished, with a PC counted modulo 1024.
    int  mPc = 0;
    bit  mRun = 0;
    bit  mHalted = 0;
    bit  mWrap = 0;
    int  mCount = 0;
    int  entry [3] = '{0, 256, 512};

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mPc = 0; mRun = 0; mHalted = 0; mWrap = 0; mCount = 0;
        end else if (!mRun) begin
            if (start_i) begin
                mRun = 1;
                mHalted = 0;
                mPc = (int'(progSel_i) < 3) ? entry[progSel_i] : 0;
                mWrap = 0;
                mCount = 0;
            end
        end else if (!stall_i) begin
            if (mCount < 65535) mCount = mCount + 1;
            if (halt_i) begin
                mRun = 0;
                mHalted = 1;
            end else if (branchEn_i) begin
                mPc = int'(target_i);
            end else begin
                if (mPc == 1023) mWrap = 1;
                mPc = (mPc + 1) % 1024;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs are all registered, so comparing on the falling edge is race-free.
    always @(negedge clk_i) begin
        checkOutput("model.addr",  int'(instAddress_o), mPc);
        checkOutput("model.valid", int'(instValid_o),   int'(mRun));
        checkOutput("model.done",  int'(done_o),        int'(mHalted));
        checkOutput("model.wrap",  int'(wrapped_o),     int'(mWrap));
`ifdef FETCH_INST_COUNT_EN
        checkOutput("model.count", int'(instCount_o),   mCount);
`endif
    end

    // Drives one cycle of inputs across a rising edge, returning at the next falling edge.
    task automatic applyStimulus(input bit st, input logic [1:0] sel, input bit stl,
                                 input bit hlt, input bit br, input logic [9:0] tgt);
        start_i = st; progSel_i = sel; stall_i = stl;
        halt_i = hlt; branchEn_i = br; target_i = tgt;
        @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);
        checkOutput("reset.addr",  int'(instAddress_o), 0);
        checkOutput("reset.valid", int'(instValid_o),   0);
        checkOutput("reset.done",  int'(done_o),        0);
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("idle.valid", int'(instValid_o), 0);

        // Program 1 runs 256..260 and halts on 260.
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("p1.entry", int'(instAddress_o), 256);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("p1.last", int'(instAddress_o), 260);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("p1.haltAddr", int'(instAddress_o), 260);
        checkOutput("p1.done",     int'(done_o),        1);
`ifdef FETCH_INST_COUNT_EN
        checkOutput("p1.count", int'(instCount_o), 5);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("p1.doneLevel", int'(done_o), 1);

        // Branch, and a branch dropped by a coincident stall.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("br.doneDrop", int'(done_o), 0);
        applyStimulus(0, 0, 0, 0, 1, 10'd10);
        applyStimulus(0, 0, 1, 0, 1, 10'd3);
        checkOutput("br.stalled", int'(instAddress_o), 10);
        applyStimulus(0, 0, 0, 0, 1, 10'd3);
        checkOutput("br.taken", int'(instAddress_o), 3);

        // Stall masks Halt until it drops.
        applyStimulus(0, 0, 0, 0, 1, 10'd20);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 0);
            checkOutput("stall.pc",    int'(instAddress_o), 20);
            checkOutput("stall.valid", int'(instValid_o),   1);
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("stall.halted", int'(done_o), 1);

        // Wrap past the top of the ROM; a restart clears the sticky flag.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 10'd1022);
        checkOutput("wrap.branch", int'(wrapped_o), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap.top", int'(instAddress_o), 1023);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap.addr", int'(instAddress_o), 0);
        checkOutput("wrap.flag", int'(wrapped_o),     1);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("wrap.haltWins", int'(done_o),    1);
        checkOutput("wrap.sticky",   int'(wrapped_o), 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("wrap.cleared", int'(wrapped_o), 0);
        checkOutput("wrap.restart", int'(instValid_o), 1);

        // Unmapped ProgSel and Start ignored during RUN.
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkOutput("sel3.addr", int'(instAddress_o), 0);
        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("runStart.noReload", int'(instAddress_o), 1);

        // Asynchronous reset mid-run at PC=37.
        applyStimulus(0, 0, 0, 0, 1, 10'd37);
        checkOutput("rst.pre", int'(instAddress_o), 37);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst.addr",  int'(instAddress_o), 0);
        checkOutput("rst.valid", int'(instValid_o),   0);
        checkOutput("rst.done",  int'(done_o),        0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("p2.entry", int'(instAddress_o), 512);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("p2.next", int'(instAddress_o), 513);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and fetch sequencer for the 3BC processor. It drives the 10-bit InstAddress into the instruction ROM and sequences a program from Start to halt.
- Selects one of several program entry points, advances or branches the PC, honours pipeline stalls, and reports completion to the testbench via a Start/Done handshake.

Parameters:
- ADDR_W, 10, instruction address width (ROM depth 2**ADDR_W).
- NUM_PROGS, 3, number of selectable program entry points.
- PROG_SEL_W, 2, width of ProgSel; must satisfy 2**PROG_SEL_W >= NUM_PROGS.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  level/pulse from testbench; sampled only in IDLE or HALT.
- ProgSel  in  PROG_SEL_W  program index latched with Start.
- Stall  in  1  datapath hazard; freezes PC and state.
- Halt  in  1  decoder saw halt instruction at current InstAddress.
- BranchEn  in  1  taken branch this cycle.
- Target  in  ADDR_W  absolute branch target.
- InstAddress  out  ADDR_W  ROM address (registered PC).
- InstValid  out  1  InstOut from ROM is a live instruction.
- Done  out  1  program complete (Ack to testbench).
- Wrapped  out  1  sticky: PC wrapped past 2**ADDR_W-1 this run.

Behaviour:
- Clock and reset: single clock Clk; Reset is asynchronous, active-low.
- Reset values: state=IDLE, InstAddress=0, InstValid=0, Done=0, Wrapped=0.
- States:
  - IDLE: InstValid=0, Done=0.
  - RUN: InstValid=1, Done=0.
  - HALT: InstValid=0, Done=1.
- IDLE/HALT -> RUN when Start=1 at an edge:
  - PC <= START_ADDR[ProgSel], Wrapped <= 0, Done <= 0.
  - ProgSel >= NUM_PROGS loads address 0.
- RUN, per edge, in priority order:
  - Stall=1: hold PC and state; Halt and BranchEn are ignored.
  - Halt=1: state -> HALT, PC holds (points at the halt instruction).
  - BranchEn=1: PC <= Target.
  - Otherwise: PC <= PC+1, modulo 2**ADDR_W.
- Latency: PC change is visible on InstAddress the edge after the decision; ROM is combinational, so InstOut is valid in the same cycle.
- Wrap-around: PC=2**ADDR_W-1 incrementing goes to 0 and sets Wrapped=1. Wrapped stays set until the next Start. A branch never sets Wrapped.
- Start during RUN: ignored.
- Start held high in HALT: restarts immediately (Done drops the next cycle).
- Start and Halt both high in RUN: Halt wins.
- Reset mid-run: immediate return to reset values; no Done pulse.
- Done is level: stays 1 in HALT until Start.

Optional Feature:
- Macro: FETCH_INST_COUNT_EN.
- Defined: adds output InstCount [15:0]. It is cleared on Start and increments on each RUN edge with Stall=0, counting the halt cycle too. It saturates at 16'hFFFF and resets to 0.
- Undefined: port, counter and logic absent; no other behaviour change.

Decomposition:
- Package fetch_pkg:
  - ADDR_W, NUM_PROGS.
  - typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t.
  - typedef logic [ADDR_W-1:0] inst_addr_t.
  - Constant array START_ADDR[NUM_PROGS] = {10'd0, 10'd256, 10'd512}.
- Sub-module: pc_next (combinational next-PC mux plus wrap detect). The FSM and registers stay in fetch_ctrl.

Test Plan:
- Reset low mid-RUN at PC=37 -> InstAddress=0, InstValid=0, Done=0 asynchronously, before the next edge.
- Start=1, ProgSel=1, no branches, Halt at PC=260 -> addresses 256..260 over 5 cycles, then Done=1, InstAddress holds 260; InstCount=5 with FETCH_INST_COUNT_EN.
- RUN at PC=10, BranchEn=1, Target=3 -> next InstAddress=3; with Stall=1 in the same cycle -> PC stays 10 and the branch is dropped.
- Stall=1 for 3 cycles at PC=20 while Halt=1 -> PC held at 20, no HALT; Stall drops -> HALT next edge.
- Start with ProgSel=0, Target=1022 branch, then two increments -> 1022, 1023, 0 and Wrapped=1; next Start -> Wrapped=0.
- ProgSel=3 with Start -> PC=0; Start pulsed during RUN -> no PC reload.
